// File: rtl/mux4x1_rr_sel.sv
// Round-robin select generator driving the 2-bit select of a 4:1 mux, with bounded grant hold.
// Optional MUX_SEL_LOCK_EN adds a `lock` input that suspends hold expiry while asserted.
module mux4x1_rr_sel #(
   parameter int unsigned HOLD_MAX = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       rel,
`ifdef MUX_SEL_LOCK_EN
   input  logic       lock,
`endif
   output logic [1:0] sel,
   output logic [3:0] gnt,
   output logic       valid,
   output logic [7:0] hold_cnt
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

   state_t     state, state_nx;
   logic [1:0] last, last_nx;
   logic [1:0] sel_nx;
   logic [3:0] gnt_nx;
   logic       valid_nx;
   logic [7:0] hold_nx;
   logic [3:0] drop_mask, cand;
   logic [2:0] pick;
   logic       expired, end_cond;

   // Returns {found, channel}: first set bit of cand searching start+1 .. start+4 (mod 4).
   function automatic logic [2:0] rr_pick(input logic [3:0] c, input logic [1:0] start);
      logic [2:0] r;
      logic [1:0] idx;
      r = 3'b000;
      for (int k = 4; k >= 1; k--) begin
         idx = start + 2'(k);
         if (c[idx]) r = {1'b1, idx};
      end
      return r;
   endfunction

   always_comb begin
      state_nx  = state;
      last_nx   = last;
      sel_nx    = sel;
      gnt_nx    = gnt;
      valid_nx  = valid;
      hold_nx   = hold_cnt;
      // A released channel may not win the same-edge re-arbitration.
      drop_mask = (state == GRANT && rel) ? (4'b0001 << sel) : 4'b0000;
      cand      = req & ~drop_mask;
      pick      = rr_pick(cand, last);
`ifdef MUX_SEL_LOCK_EN
      expired   = !lock && (hold_cnt >= HOLD_LAST);
`else
      expired   = (hold_cnt >= HOLD_LAST);
`endif
      end_cond  = rel || !req[sel] || expired;

      case (state)
         IDLE: begin
            valid_nx = 1'b0;
            gnt_nx   = 4'b0000;
            hold_nx  = 8'd0;
            if (pick[2]) begin
               state_nx = GRANT;
               sel_nx   = pick[1:0];
               gnt_nx   = 4'b0001 << pick[1:0];
               valid_nx = 1'b1;
               last_nx  = pick[1:0];
            end
         end
         GRANT: begin
            if (!end_cond) begin
               hold_nx = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
            end else if (pick[2]) begin
               sel_nx   = pick[1:0];
               gnt_nx   = 4'b0001 << pick[1:0];
               valid_nx = 1'b1;
               hold_nx  = 8'd0;
               last_nx  = pick[1:0];
            end else begin
               state_nx = IDLE;
               gnt_nx   = 4'b0000;
               valid_nx = 1'b0;
               hold_nx  = 8'd0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         last     <= 2'd3;
         sel      <= 2'd0;
         gnt      <= 4'b0000;
         valid    <= 1'b0;
         hold_cnt <= 8'd0;
      end else begin
         state    <= state_nx;
         last     <= last_nx;
         sel      <= sel_nx;
         gnt      <= gnt_nx;
         valid    <= valid_nx;
         hold_cnt <= hold_nx;
      end
   end

   a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
   a_gnt_valid   : assert property (@(posedge clk) disable iff (!rst_n) ((gnt != 4'b0000) == valid));
   a_gnt_sel     : assert property (@(posedge clk) disable iff (!rst_n) (valid -> (gnt == (4'b0001 << sel))));

endmodule
